// File: rtl/blake2_hash.sv
// BLAKE2b (W=64) / BLAKE2s (W=32) compression engine: one block in,
// one round per cycle, chaining state held across blocks of a message.
module blake2_hash #(
  parameter int unsigned W = 64
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [7:0]              kk_i,
  input  logic [7:0]              nn_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    first_i,
  input  logic                    last_i,
  input  logic [$clog2(2*W):0]    len_i,
  input  logic [16*W-1:0]         d_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [8*W-1:0]          h_o
);

  localparam int unsigned R   = (W == 64) ? 12 : 10;
  localparam int unsigned RT0 = (W == 64) ? 32 : 16;
  localparam int unsigned RT1 = (W == 64) ? 24 : 12;
  localparam int unsigned RT2 = (W == 64) ? 16 : 8;
  localparam int unsigned RT3 = (W == 64) ? 63 : 7;
  localparam int unsigned TW  = 2 * W;

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   h_q [8];
  logic [W-1:0]   h_d [8];
  logic [TW-1:0]  t_q, t_d;
  logic           f_q, f_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [W-1:0]   v_q [16];
  logic [W-1:0]   v_d [16];
  logic [W-1:0]   m_q [16];
  logic [W-1:0]   m_d [16];
  logic [W-1:0]   vr [16];
  logic [63:0]    srow;
  logic [3:0]     sidx;

  // BLAKE2s IV words are the upper halves of the BLAKE2b IV words
  function automatic logic [W-1:0] iv(input logic [2:0] i);
    logic [63:0] x;
    case (i)
      3'd0:    x = 64'h6a09e667f3bcc908;
      3'd1:    x = 64'hbb67ae8584caa73b;
      3'd2:    x = 64'h3c6ef372fe94f82b;
      3'd3:    x = 64'ha54ff53a5f1d36f1;
      3'd4:    x = 64'h510e527fade682d1;
      3'd5:    x = 64'h9b05688c2b3e6c1f;
      3'd6:    x = 64'h1f83d9abfb41bd6b;
      default: x = 64'h5be0cd19137e2179;
    endcase
    return W'(x >> (64 - W));
  endfunction

  // message schedule row; nibble k holds SIGMA[r][k]
  function automatic logic [63:0] sigma_row(input logic [3:0] r);
    case (r)
      4'd0:    return 64'hfedcba9876543210;
      4'd1:    return 64'h357b20c16df984ae;
      4'd2:    return 64'h491763eadf250c8b;
      4'd3:    return 64'h8f04a562ebcd1397;
      4'd4:    return 64'hd386cb1efa427509;
      4'd5:    return 64'h91ef57d438b0a6c2;
      4'd6:    return 64'hb8293670a4def15c;
      4'd7:    return 64'ha2684f05931ce7bd;
      4'd8:    return 64'h5a417d2c803b9ef6;
      default: return 64'h0dc3e9bf5167482a;
    endcase
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  // BLAKE2 G mixing function, returns {a, b, c, d}
  function automatic logic [4*W-1:0] g_mix(input logic [W-1:0] ai, bi, ci, di, xi, yi);
    logic [W-1:0] a, b, c, d;
    a = ai + bi + xi;
    d = rotr(di ^ a, RT0);
    c = ci + d;
    b = rotr(bi ^ c, RT1);
    a = a + b + yi;
    d = rotr(d ^ a, RT2);
    c = c + d;
    b = rotr(b ^ c, RT3);
    return {a, b, c, d};
  endfunction

  // one full round on the working vector: 4 column G then 4 diagonal G
  always_comb begin
    sidx = (rnd_q >= 4'd10) ? rnd_q - 4'd10 : rnd_q;
    srow = sigma_row(sidx);
    vr   = v_q;
    {vr[0], vr[4], vr[8],  vr[12]} = g_mix(vr[0], vr[4], vr[8],  vr[12], m_q[srow[3:0]],   m_q[srow[7:4]]);
    {vr[1], vr[5], vr[9],  vr[13]} = g_mix(vr[1], vr[5], vr[9],  vr[13], m_q[srow[11:8]],  m_q[srow[15:12]]);
    {vr[2], vr[6], vr[10], vr[14]} = g_mix(vr[2], vr[6], vr[10], vr[14], m_q[srow[19:16]], m_q[srow[23:20]]);
    {vr[3], vr[7], vr[11], vr[15]} = g_mix(vr[3], vr[7], vr[11], vr[15], m_q[srow[27:24]], m_q[srow[31:28]]);
    {vr[0], vr[5], vr[10], vr[15]} = g_mix(vr[0], vr[5], vr[10], vr[15], m_q[srow[35:32]], m_q[srow[39:36]]);
    {vr[1], vr[6], vr[11], vr[12]} = g_mix(vr[1], vr[6], vr[11], vr[12], m_q[srow[43:40]], m_q[srow[47:44]]);
    {vr[2], vr[7], vr[8],  vr[13]} = g_mix(vr[2], vr[7], vr[8],  vr[13], m_q[srow[51:48]], m_q[srow[55:52]]);
    {vr[3], vr[4], vr[9],  vr[14]} = g_mix(vr[3], vr[4], vr[9],  vr[14], m_q[srow[59:56]], m_q[srow[63:60]]);
  end

  // next state: block accept, round sequencing, finalisation, digest handshake
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    t_d     = t_q;
    f_d     = f_q;
    rnd_d   = rnd_q;
    v_d     = v_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (first_i) begin
            for (int i = 0; i < 8; i++) h_d[i] = iv(3'(i));
            h_d[0] = iv(3'd0) ^ W'(32'h0101_0000) ^ (W'(kk_i) << 8) ^ W'(nn_i);
            t_d    = TW'(len_i);
          end else begin
            t_d = t_q + TW'(len_i);
          end
          for (int i = 0; i < 16; i++) m_d[i] = d_i[W*i +: W];
          for (int i = 0; i < 8; i++) begin
            v_d[i]     = h_d[i];
            v_d[i + 8] = iv(3'(i));
          end
          v_d[12] = v_d[12] ^ t_d[W-1:0];
          v_d[13] = v_d[13] ^ t_d[TW-1:W];
          v_d[14] = v_d[14] ^ {W{last_i}};
          f_d     = last_i;
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        v_d   = vr;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(R - 1)) begin
          for (int i = 0; i < 8; i++) h_d[i] = h_q[i] ^ vr[i] ^ vr[i + 8];
          state_d = f_q ? OUT : IDLE;
        end
      end
      OUT: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control and chaining state, cleared to an idle engine with IV loaded
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) h_q[i] <= iv(3'(i));
      t_q     <= '0;
      f_q     <= 1'b0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      t_q     <= t_d;
      f_q     <= f_d;
      rnd_q   <= rnd_d;
    end
  end

  // working vector and message words carry no reset
  always_ff @(posedge clk) begin
    v_q <= v_d;
    m_q <= m_d;
  end

  // handshake and digest output decoded from the state register
  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == OUT);
    for (int i = 0; i < 8; i++) h_o[W*i +: W] = (state_q == OUT) ? h_q[i] : '0;
  end

endmodule

// File: tb/tb_blake2_hash.sv
// Directed bench for blake2_hash: RFC 7693 "abc" vectors for both widths,
// multi-block streaming, backpressure, chain restart and mid-round reset.
module tb_blake2_hash;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  // W=64 instance
  logic          v64, rdy64, f64, l64, vo64, ri64;
  logic [7:0]    kk64, nn64, len64;
  logic [1023:0] d64;
  logic [511:0]  h64;

  // W=32 instance
  logic          v32, rdy32, f32, l32, vo32, ri32;
  logic [7:0]    kk32, nn32;
  logic [6:0]    len32;
  logic [511:0]  d32;
  logic [255:0]  h32;

  blake2_hash #(.W(64)) dut64 (
    .clk(clk), .nreset(nreset), .kk_i(kk64), .nn_i(nn64),
    .valid_i(v64), .ready_o(rdy64), .first_i(f64), .last_i(l64),
    .len_i(len64), .d_i(d64), .valid_o(vo64), .ready_i(ri64), .h_o(h64)
  );

  blake2_hash #(.W(32)) dut32 (
    .clk(clk), .nreset(nreset), .kk_i(kk32), .nn_i(nn32),
    .valid_i(v32), .ready_o(rdy32), .first_i(f32), .last_i(l32),
    .len_i(len32), .d_i(d32), .valid_o(vo32), .ready_i(ri32), .h_o(h32)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference BLAKE2b model ----------------
  logic [63:0] iv_tb [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                             64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                             64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                             64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  int sig [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};
  logic [63:0] mh [8];
  logic [63:0] mv [16];
  logic [63:0] mm [16];

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic mg(input int a, input int b, input int c, input int d,
                    input logic [63:0] x, input logic [63:0] y);
    mv[a] = mv[a] + mv[b] + x;  mv[d] = ror(mv[d] ^ mv[a], 32);
    mv[c] = mv[c] + mv[d];      mv[b] = ror(mv[b] ^ mv[c], 24);
    mv[a] = mv[a] + mv[b] + y;  mv[d] = ror(mv[d] ^ mv[a], 16);
    mv[c] = mv[c] + mv[d];      mv[b] = ror(mv[b] ^ mv[c], 63);
  endtask

  task automatic model_init(input logic [7:0] nn);
    for (int i = 0; i < 8; i++) mh[i] = iv_tb[i];
    mh[0] = mh[0] ^ 64'h0101_0000 ^ {56'd0, nn};
  endtask

  task automatic model_compress(input logic [1023:0] blk, input logic [127:0] t, input bit last);
    for (int i = 0; i < 16; i++) mm[i] = blk[64*i +: 64];
    for (int i = 0; i < 8; i++) begin
      mv[i]     = mh[i];
      mv[i + 8] = iv_tb[i];
    end
    mv[12] = mv[12] ^ t[63:0];
    mv[13] = mv[13] ^ t[127:64];
    if (last) mv[14] = ~mv[14];
    for (int r = 0; r < 12; r++) begin
      int s;
      s = r % 10;
      mg(0, 4,  8, 12, mm[sig[s][0]],  mm[sig[s][1]]);
      mg(1, 5,  9, 13, mm[sig[s][2]],  mm[sig[s][3]]);
      mg(2, 6, 10, 14, mm[sig[s][4]],  mm[sig[s][5]]);
      mg(3, 7, 11, 15, mm[sig[s][6]],  mm[sig[s][7]]);
      mg(0, 5, 10, 15, mm[sig[s][8]],  mm[sig[s][9]]);
      mg(1, 6, 11, 12, mm[sig[s][10]], mm[sig[s][11]]);
      mg(2, 7,  8, 13, mm[sig[s][12]], mm[sig[s][13]]);
      mg(3, 4,  9, 14, mm[sig[s][14]], mm[sig[s][15]]);
    end
    for (int i = 0; i < 8; i++) mh[i] = mh[i] ^ mv[i] ^ mv[i + 8];
  endtask

  function automatic logic [511:0] model_digest();
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = mh[i];
    return r;
  endfunction

  // digest written in reading order -> byte 0 in the low byte
  function automatic logic [511:0] le_bytes(input logic [511:0] be, input int nb);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < nb; k++) r[8*k +: 8] = be[8*(nb-1-k) +: 8];
    return r;
  endfunction

  // 273-byte test message split into 128-byte blocks
  function automatic logic [1023:0] blk_data(input int j);
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 128; i++)
      if (128*j + i < 273) r[8*i +: 8] = 8'((128*j + i) * 37 + 11);
    return r;
  endfunction

  // ---------------- drivers (enter and leave on a falling edge) ----------------
  task automatic push64(input bit first, input bit last, input logic [7:0] len,
                        input logic [1023:0] d, input logic [7:0] nn);
    int n;
    n = 0;
    f64 = first; l64 = last; len64 = len; d64 = d; kk64 = 8'd0; nn64 = nn; v64 = 1'b1;
    while (!rdy64 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("push64_timeout", 0, 1);
    @(negedge clk);
    v64 = 1'b0;
  endtask

  task automatic push32(input bit first, input bit last, input logic [6:0] len,
                        input logic [511:0] d, input logic [7:0] nn);
    int n;
    n = 0;
    f32 = first; l32 = last; len32 = len; d32 = d; kk32 = 8'd0; nn32 = nn; v32 = 1'b1;
    while (!rdy32 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("push32_timeout", 0, 1);
    @(negedge clk);
    v32 = 1'b0;
  endtask

  // cycles counted from the accept cycle to the first cycle with valid_o high
  task automatic wait_out64(output int cnt);
    cnt = 1;
    while (!vo64 && cnt < 200) begin @(negedge clk); cnt++; end
  endtask

  task automatic wait_out32(output int cnt);
    cnt = 1;
    while (!vo32 && cnt < 200) begin @(negedge clk); cnt++; end
  endtask

  task automatic release64(input string tag);
    ri64 = 1'b1;
    @(negedge clk);
    ri64 = 1'b0;
    chk({tag, "_rel_valid"}, vo64, 0);
    chk({tag, "_rel_ready"}, rdy64, 1);
    chk({tag, "_rel_hzero"}, h64, 0);
  endtask

  // ---------------- main sequence ----------------
  logic [511:0]  e64, e32, hsave, exp_stream;
  logic [1023:0] abc64;
  logic [511:0]  abc32;
  logic [127:0]  texp [3];
  int            lat, low;
  bit            ok;

  initial begin
    e64 = le_bytes(512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923, 64);
    e32 = le_bytes(512'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982, 32);
    abc64 = '0; abc64[23:0] = 24'h636261;
    abc32 = '0; abc32[23:0] = 24'h636261;
    texp[0] = 128'd128; texp[1] = 128'd256; texp[2] = 128'd273;

    nreset = 1'b0;
    v64 = 0; f64 = 0; l64 = 0; ri64 = 0; kk64 = 0; nn64 = 0; len64 = 0; d64 = '0;
    v32 = 0; f32 = 0; l32 = 0; ri32 = 0; kk32 = 0; nn32 = 0; len32 = 0; d32 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready64", rdy64, 1);
    chk("rst_valid64", vo64, 0);
    chk("rst_h64", h64, 0);
    chk("rst_ready32", rdy32, 1);
    chk("rst_h32", h32, 0);
    nreset = 1'b1;
    @(negedge clk);

    // reference model against the published vector
    model_init(8'd64);
    model_compress(abc64, 128'd3, 1'b1);
    chk("model_abc", model_digest(), e64);

    // BLAKE2b("abc") with output backpressure
    push64(1'b1, 1'b1, 8'd3, abc64, 8'd64);
    wait_out64(lat);
    chk("abc64_latency", lat, 13);
    chk("abc64_digest", h64, e64);
    chk("out_ready_low", rdy64, 0);
    hsave = h64;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!vo64 || h64 !== hsave || rdy64) ok = 1'b0;
    end
    chk("bp_stable", ok, 1);
    release64("abc64");

    // BLAKE2s("abc")
    push32(1'b1, 1'b1, 7'd3, abc32, 8'd32);
    wait_out32(lat);
    chk("abc32_latency", lat, 11);
    chk("abc32_digest", h32, e32);
    ri32 = 1'b1;
    @(negedge clk);
    ri32 = 1'b0;
    chk("abc32_rel_valid", vo32, 0);
    chk("abc32_rel_hzero", h32, 0);

    // 3-block streaming message, valid_i held high between blocks
    model_init(8'd64);
    model_compress(blk_data(0), texp[0], 1'b0);
    model_compress(blk_data(1), texp[1], 1'b0);
    model_compress(blk_data(2), texp[2], 1'b1);
    exp_stream = model_digest();
    f64 = 1'b1; l64 = 1'b0; len64 = 8'd128; d64 = blk_data(0); kk64 = 8'd0; nn64 = 8'd64; v64 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("stream_t%0d", j), dut64.t_q, texp[j]);
      if (j < 2) begin
        f64 = 1'b0; l64 = (j == 1); len64 = (j == 1) ? 8'd17 : 8'd128; d64 = blk_data(j + 1);
        low = 0;
        while (!rdy64 && low < 50) begin low++; @(negedge clk); end
        chk($sformatf("stream_gap%0d", j), low, 12);
      end else begin
        v64 = 1'b0;
      end
    end
    wait_out64(lat);
    chk("stream_latency", lat, 13);
    chk("stream_digest", h64, exp_stream);
    release64("stream");

    // first_i mid-message restarts the chain
    push64(1'b1, 1'b0, 8'd128, blk_data(0), 8'd64);
    push64(1'b1, 1'b1, 8'd3, abc64, 8'd64);
    wait_out64(lat);
    chk("restart_digest", h64, e64);
    release64("restart");

    // reset during round 5 aborts the block asynchronously
    push64(1'b1, 1'b1, 8'd3, abc64, 8'd64);
    repeat (5) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("midrst_ready", rdy64, 1);
    chk("midrst_valid", vo64, 0);
    chk("midrst_h", h64, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    push64(1'b1, 1'b1, 8'd3, abc64, 8'd64);
    wait_out64(lat);
    chk("postrst_latency", lat, 13);
    chk("postrst_digest", h64, e64);
    release64("postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/blake2_hash.md
BLAKE2_HASH -- requirements
Module: blake2_hash

Interface
REQ-001 Parameter: W, default 64, word width in bits; legal values 64 (BLAKE2b) and 32 (BLAKE2s).
REQ-002 Derived constants: W=64 -> R=12 rounds, rotations 32/24/16/63; W=32 -> R=10 rounds, rotations 16/12/8/7; block size BB=2*W bytes.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 kk_i  input  8  key length in bytes, sampled on a first-block accept.
REQ-006 nn_i  input  8  digest length in bytes, sampled on a first-block accept.
REQ-007 valid_i  input  1  block offered.
REQ-008 ready_o  output  1  block can be accepted.
REQ-009 first_i  input  1  offered block is the first block of a message.
REQ-010 last_i  input  1  offered block is the final block of a message.
REQ-011 len_i  input  clog2(BB)+1  valid bytes in the offered block, range 0..BB.
REQ-012 d_i  input  16*W  message block; word i at [W*i+W-1:W*i], little-endian bytes, unused bytes zero.
REQ-013 valid_o  output  1  digest available.
REQ-014 ready_i  input  1  downstream accepts the digest.
REQ-015 h_o  output  8*W  chaining/digest state; word i at [W*i+W-1:W*i], digest byte 0 at h_o[7:0].

Function
REQ-016 States: IDLE, ROUND, OUT; ready_o=1 only in IDLE; valid_o=1 only in OUT.
REQ-017 Accept occurs on a rising edge with valid_i&ready_o; inputs are ignored at all other times.
REQ-018 On accept with first_i=1: h <= IV ^ 0x01010000 ^ (kk_i<<8) ^ nn_i in word 0, IV in words 1..7; t <= len_i.
REQ-019 On accept with first_i=0: h is retained; t <= t + len_i, with t 2W bits wide and wrapping modulo 2^(2W).
REQ-020 On accept: m <= d_i; v[0..7] <= h; v[8..15] <= IV; v[12] ^= t[W-1:0]; v[13] ^= t[2W-1:W]; if last_i then v[14] ^= all-ones. All of these use the post-update h and t.
REQ-021 On accept: f_q <= last_i; round counter <= 0; state -> ROUND.
REQ-022 ROUND: each cycle applies one full BLAKE2 round (4 column G, then 4 diagonal G) using SIGMA[round mod 10]; additions are modulo 2^W; the round counter increments.
REQ-023 On the edge where the round counter equals R-1: h <= h ^ v_next[0..7] ^ v_next[8..15]; state -> OUT if f_q, else IDLE.
REQ-024 Latency: accept at edge 0; h is final at edge R. ready_o (non-last) or valid_o (last) is asserted in the cycle after edge R. Sustained throughput is one block per R+1 cycles.
REQ-025 OUT: valid_o and h_o are held stable until ready_i=1; on that edge state -> IDLE. No new block is accepted in the same cycle.
REQ-026 h_o = h when valid_o=1, else all-zero.
REQ-027 first_i=1 with last_i=1: single-block message. first_i=1 arriving mid-message restarts the chain (previous h and t discarded).
REQ-028 Keyed hashing: the caller supplies the zero-padded key block as the first block with len_i=BB and kk_i>0. The block applies no internal key handling.
REQ-029 len_i=0 is legal only for a first+last empty message; t becomes 0.
REQ-030 The full 8-word state is always output; truncation to nn bytes is performed downstream.

Reset
REQ-031 While nreset=0: state=IDLE, h=IV, t=0, f_q=0, round counter=0, valid_o=0, h_o=0, ready_o=1. v and m are not reset.
REQ-032 Assertion mid-ROUND or mid-OUT aborts the message immediately. After release, the next accepted block must carry first_i=1 for a defined result.

Verification
REQ-033 W=64, one block d_i[23:0]=24'h636261, first/last=1, len=3, kk=0, nn=64 -> valid_o rises 13 cycles after accept. h_o is BLAKE2b("abc") = BA80A53F...4009923 (RFC 7693 App. A), with 0xBA at h_o[7:0].
REQ-034 W=32, same "abc" stimulus, nn=32 -> valid_o after 11 cycles; h_o[255:0] is BLAKE2s("abc") = 508C5E8C...86675982.
REQ-035 W=64, 3-block message (128+128+17 bytes, random data) with valid_i held high -> ready_o drops for exactly 12 cycles per block; t sequence is 128, 256, 273; digest matches the software model.
REQ-036 Output backpressure: ready_i=0 for 20 cycles in OUT -> valid_o and h_o stay constant and ready_o stays 0; ready_i=1 -> IDLE on the next edge.
REQ-037 Reset asserted at round 5 of a block -> valid_o=0, h_o=0, ready_o=1 asynchronously. A following "abc" single-block message yields the correct digest.
REQ-038 first_i=1 issued after 1 non-last block -> the digest equals that of the new message alone.
